// File: rtl/sdram_init_seq.sv
// ---------------------------------------------------------------------------
// sdram_init_seq : SDR SDRAM power-up command sequencer (wait, PRECHARGE ALL,
//                  N x AUTO REFRESH, LOAD MODE, then sticky done). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_init_seq #(
  parameter int unsigned P_WAIT_CYCLES = 10000,
  parameter int unsigned P_TRP         = 2,
  parameter int unsigned P_TRC         = 7,
  parameter int unsigned P_TMRD        = 2,
  parameter int unsigned P_REF_NUM     = 2,
  parameter logic [12:0] P_MODE_REG    = 13'h0037
) (
  input  logic        s_clk,
  input  logic        s_rst,
  output logic        o_cke,
  output logic [3:0]  o_cmd,
  output logic [1:0]  o_ba,
  output logic [12:0] o_addr,
  output logic        o_init_done
);

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_TRP  = 3'd2;
  localparam logic [2:0] S_REF  = 3'd3;
  localparam logic [2:0] S_TRC  = 3'd4;
  localparam logic [2:0] S_MRS  = 3'd5;
  localparam logic [2:0] S_TMRD = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // Spacing states are entered one cycle after the command, hence the -2.
  localparam logic [15:0] WAIT_LOAD = 16'(P_WAIT_CYCLES);
  localparam logic [15:0] TRP_LOAD  = 16'(P_TRP - 2);
  localparam logic [15:0] TRC_LOAD  = 16'(P_TRC - 2);
  localparam logic [15:0] TMRD_LOAD = 16'(P_TMRD - 2);
  localparam logic [3:0]  REF_LOAD  = 4'(P_REF_NUM);

  logic [2:0]  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0]  ref_left, ref_left_nx;
  logic [3:0]  cmd_nx;
  logic [12:0] addr_nx;

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state       <= S_WAIT;
      cnt         <= WAIT_LOAD;
      ref_left    <= REF_LOAD;
      o_cke       <= 1'b0;
      o_cmd       <= CMD_INH;
      o_ba        <= 2'b00;
      o_addr      <= 13'h0000;
      o_init_done <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ref_left    <= ref_left_nx;
      o_cke       <= 1'b1;
      o_cmd       <= cmd_nx;
      o_ba        <= 2'b00;
      o_addr      <= addr_nx;
      o_init_done <= (state_nx == S_DONE);
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ref_left_nx = ref_left;
    case (state)
      S_WAIT: begin
        if (cnt == 16'd0) begin
          state_nx    = S_PRE;
          ref_left_nx = REF_LOAD;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      S_PRE: begin
        if (P_TRP == 1) begin
          state_nx = S_REF;
        end else begin
          state_nx = S_TRP;
          cnt_nx   = TRP_LOAD;
        end
      end
      S_TRP: begin
        if (cnt == 16'd0) state_nx = S_REF;
        else              cnt_nx   = cnt - 16'd1;
      end
      S_REF: begin
        ref_left_nx = ref_left - 4'd1;
        if (P_TRC == 1) begin
          state_nx = (ref_left == 4'd1) ? S_MRS : S_REF;
        end else begin
          state_nx = S_TRC;
          cnt_nx   = TRC_LOAD;
        end
      end
      S_TRC: begin
        if (cnt == 16'd0) state_nx = (ref_left == 4'd0) ? S_MRS : S_REF;
        else              cnt_nx   = cnt - 16'd1;
      end
      S_MRS: begin
        if (P_TMRD == 1) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_TMRD;
          cnt_nx   = TMRD_LOAD;
        end
      end
      S_TMRD: begin
        if (cnt == 16'd0) state_nx = S_DONE;
        else              cnt_nx   = cnt - 16'd1;
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so the pins update with the state.
  always_comb begin
    cmd_nx  = CMD_NOP;
    addr_nx = 13'h0000;
    case (state_nx)
      S_PRE: begin
        cmd_nx  = CMD_PRE;
        addr_nx = 13'h0400;
      end
      S_REF: cmd_nx = CMD_REF;
      S_MRS: begin
        cmd_nx  = CMD_MRS;
        addr_nx = P_MODE_REG;
      end
      default: cmd_nx = CMD_NOP;
    endcase
  end

endmodule

`default_nettype wire
